// File: rtl/fb_port_arbiter_if.sv
// Bundle of scanout read, decoder write, bank-swap and block-RAM signals for fb_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's.
interface fb_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ready;
  logic                  rd_rsp_valid;
  logic [DATA_WIDTH-1:0] rd_rsp_data;

  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  wr_frame_done;

  logic                  vsync;
  logic                  front_bank;
  logic                  swapped;

  logic [ADDR_WIDTH:0]   ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;

  modport slave (
    input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data, wr_frame_done, vsync, ram_q,
    output rd_ready, rd_rsp_valid, rd_rsp_data, wr_ready, front_bank, swapped,
    output ram_addr, ram_data, ram_we
  );

  modport master (
    output rd_valid, rd_addr, wr_valid, wr_addr, wr_data, wr_frame_done, vsync, ram_q,
    input  rd_ready, rd_rsp_valid, rd_rsp_data, wr_ready, front_bank, swapped,
    input  ram_addr, ram_data, ram_we
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Double-buffered framebuffer port arbiter: scanout reads win by default, the decoder writer is
// forced through after MAX_WAIT stalled cycles, and banks swap at vsync once a frame is done.
module fb_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_WAIT   = 7
) (
  input logic             clk,
  input logic             reset_n,
  fb_port_arbiter_if.slave bus
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  typedef enum logic [0:0] {StIdle, StPending} swap_state_e;

  swap_state_e           state_q, state_d;
  logic                  front_bank_q, front_bank_d;
  logic                  swapped_q, swapped_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  rd_pipe_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic swap_pending, do_swap, force_wr, rd_xfer, wr_xfer;

  // Arbitration: purely combinational from valids, starvation count and swap state.
  always_comb begin
    force_wr     = bus.wr_valid && (wait_cnt_q == MaxWait) && !swap_pending;
    bus.rd_ready = bus.rd_valid && !force_wr;
    bus.wr_ready = bus.wr_valid && !swap_pending && (!bus.rd_valid || force_wr);
    rd_xfer      = bus.rd_valid && bus.rd_ready;
    wr_xfer      = bus.wr_valid && bus.wr_ready;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.wr_valid || wr_xfer) begin
      wait_cnt_d = '0;
    end else if (!swap_pending && (wait_cnt_q != MaxWait)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Idle paths default to the read address so the port shows no spurious write.
  always_comb begin
    bus.ram_data = bus.wr_data;
    bus.ram_we   = wr_xfer && reset_n;
    bus.ram_addr = {front_bank_q, bus.rd_addr};
    if (wr_xfer) begin
      bus.ram_addr = {~front_bank_q, bus.wr_addr};
    end
  end

  // Swap FSM: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Swap FSM: next state. A coincident frame_done and vsync in idle swaps immediately.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.wr_frame_done && !bus.vsync) state_d = StPending;
      StPending: if (bus.vsync) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Swap FSM: outputs.
  always_comb begin
    swap_pending = (state_q == StPending);
    do_swap      = bus.vsync && (swap_pending || bus.wr_frame_done);
    front_bank_d = front_bank_q ^ do_swap;
    swapped_d    = do_swap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front_bank_q <= 1'b0;
      swapped_q    <= 1'b0;
      wait_cnt_q   <= '0;
      rd_pipe_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      front_bank_q <= front_bank_d;
      swapped_q    <= swapped_d;
      wait_cnt_q   <= wait_cnt_d;
      rd_pipe_q    <= rd_xfer;
      rsp_valid_q  <= rd_pipe_q;
      if (rd_pipe_q) begin
        rsp_data_q <= bus.ram_q;
      end
    end
  end

  assign bus.front_bank   = front_bank_q;
  assign bus.swapped      = swapped_q;
  assign bus.rd_rsp_valid = rsp_valid_q;
  assign bus.rd_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed-vector bench for fb_port_arbiter; the RAM is modelled as a registered read of a fixed
// address-derived pattern so returned data identifies both bank and address.
module tb_fb_port_arbiter;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  fb_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fb_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(7)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW:0] a);
    pat = a[7:0] + 8'h3C + (a[AW] ? 8'h80 : 8'h00);
  endfunction

  always_ff @(posedge clk) bus.ram_q <= pat(bus.ram_addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_valid      = 1'b0;
    bus.rd_addr       = '0;
    bus.wr_valid      = 1'b0;
    bus.wr_addr       = '0;
    bus.wr_data       = '0;
    bus.wr_frame_done = 1'b0;
    bus.vsync         = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    reset_n     = 1'b0;
    bus.wr_valid = 1'b1;
    repeat (3) step();
    #1;
    check_eq("rst_front_bank", 32'(bus.front_bank), 0);
    check_eq("rst_swapped", 32'(bus.swapped), 0);
    check_eq("rst_rsp_valid", 32'(bus.rd_rsp_valid), 0);
    check_eq("rst_rsp_data", 32'(bus.rd_rsp_data), 0);
    check_eq("rst_ram_we", 32'(bus.ram_we), 0);
    bus.wr_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // Read-only stream: transfers in cycles 0..3, responses in cycles 2..5.
    for (int i = 0; i < 7; i++) begin
      bus.rd_valid = (i < 4);
      bus.rd_addr  = AW'(i);
      #1;
      if (i < 4) begin
        check_eq("rd_ready", 32'(bus.rd_ready), 1);
        check_eq("rd_ram_addr", 32'(bus.ram_addr), 32'(i));
        check_eq("rd_ram_we", 32'(bus.ram_we), 0);
      end
      check_eq("rd_rsp_valid", 32'(bus.rd_rsp_valid), 32'(i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) begin
        check_eq("rd_rsp_data", 32'(bus.rd_rsp_data), 32'(pat({1'b0, AW'(i - 2)})));
      end
      step();
    end

    // Contention: seven read grants, then a forced write, then reads win again.
    bus.rd_valid = 1'b1;
    bus.rd_addr  = AW'(17'h00040);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(17'h00123);
    bus.wr_data  = 8'hA5;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (i == 7) begin
        check_eq("ct_force_rd_ready", 32'(bus.rd_ready), 0);
        check_eq("ct_force_wr_ready", 32'(bus.wr_ready), 1);
        check_eq("ct_force_we", 32'(bus.ram_we), 1);
        check_eq("ct_force_addr", 32'(bus.ram_addr), 32'h20123);
        check_eq("ct_force_data", 32'(bus.ram_data), 32'hA5);
      end else begin
        check_eq("ct_rd_ready", 32'(bus.rd_ready), 1);
        check_eq("ct_wr_ready", 32'(bus.wr_ready), 0);
        check_eq("ct_we", 32'(bus.ram_we), 0);
      end
      step();
    end
    idle_inputs();
    repeat (3) step();

    // Swap: frame done, writer stalled until vsync five cycles later.
    bus.wr_frame_done = 1'b1;
    step();
    bus.wr_frame_done = 1'b0;
    bus.wr_valid      = 1'b1;
    bus.wr_addr       = AW'(5);
    bus.wr_data       = 8'h5C;
    for (int i = 1; i < 5; i++) begin
      #1;
      check_eq("sw_pending_wr_ready", 32'(bus.wr_ready), 0);
      check_eq("sw_pending_we", 32'(bus.ram_we), 0);
      step();
    end
    bus.vsync = 1'b1;
    #1;
    check_eq("sw_vsync_wr_ready", 32'(bus.wr_ready), 0);
    check_eq("sw_vsync_swapped", 32'(bus.swapped), 0);
    check_eq("sw_vsync_bank", 32'(bus.front_bank), 0);
    step();
    bus.vsync = 1'b0;
    #1;
    check_eq("sw_swapped", 32'(bus.swapped), 1);
    check_eq("sw_bank", 32'(bus.front_bank), 1);
    check_eq("sw_wr_ready", 32'(bus.wr_ready), 1);
    check_eq("sw_we", 32'(bus.ram_we), 1);
    check_eq("sw_wr_addr", 32'(bus.ram_addr), 32'h00005);
    step();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = AW'(9);
    #1;
    check_eq("sw_pulse_end", 32'(bus.swapped), 0);
    check_eq("sw_rd_addr", 32'(bus.ram_addr), 32'h20009);
    step();
    bus.rd_valid = 1'b0;
    bus.vsync    = 1'b1;
    step();
    bus.vsync = 1'b0;
    #1;
    check_eq("idle_vsync_bank", 32'(bus.front_bank), 1);
    check_eq("idle_vsync_swapped", 32'(bus.swapped), 0);
    step();

    // Coincident frame done and vsync: immediate swap, writer never stalled.
    bus.wr_valid      = 1'b1;
    bus.wr_addr       = AW'(17'h00077);
    bus.wr_data       = 8'h11;
    bus.wr_frame_done = 1'b1;
    bus.vsync         = 1'b1;
    #1;
    check_eq("co_wr_ready0", 32'(bus.wr_ready), 1);
    check_eq("co_addr0", 32'(bus.ram_addr), 32'h00077);
    step();
    bus.wr_frame_done = 1'b0;
    bus.vsync         = 1'b0;
    #1;
    check_eq("co_bank", 32'(bus.front_bank), 0);
    check_eq("co_swapped", 32'(bus.swapped), 1);
    check_eq("co_wr_ready1", 32'(bus.wr_ready), 1);
    check_eq("co_addr1", 32'(bus.ram_addr), 32'h20077);
    step();
    #1;
    check_eq("co_swapped_end", 32'(bus.swapped), 0);
    check_eq("co_wr_ready2", 32'(bus.wr_ready), 1);
    idle_inputs();
    step();

    // Reset one cycle after a read transfer, with a swap also in flight.
    bus.rd_valid      = 1'b1;
    bus.rd_addr       = AW'(7);
    bus.wr_frame_done = 1'b1;
    bus.vsync         = 1'b1;
    step();
    idle_inputs();
    bus.wr_valid = 1'b1;
    #1;
    check_eq("mr_bank_pre", 32'(bus.front_bank), 1);
    check_eq("mr_swapped_pre", 32'(bus.swapped), 1);
    reset_n = 1'b0;
    #1;
    check_eq("mr_bank", 32'(bus.front_bank), 0);
    check_eq("mr_swapped", 32'(bus.swapped), 0);
    check_eq("mr_rsp_valid", 32'(bus.rd_rsp_valid), 0);
    check_eq("mr_rsp_data", 32'(bus.rd_rsp_data), 0);
    check_eq("mr_we", 32'(bus.ram_we), 0);
    bus.wr_valid = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("mr_post_rsp_valid", 32'(bus.rd_rsp_valid), 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
